// File: rtl/controle_vendas_param_pkg.sv
// Shared types and defaults for the vending-machine main controller.
package controle_vendas_param_pkg;

  localparam int unsigned StateW    = 3;
  localparam int unsigned DefCodeW  = 4;
  localparam int unsigned DefPriceW = 8;

  typedef enum logic [StateW-1:0] {
    Espera    = 3'b000,
    Consulta  = 3'b001,
    Pagamento = 3'b010,
    Dispensa  = 3'b011,
    Troco     = 3'b100
  } estado_e;

endpackage

// File: rtl/controle_vendas_param_if.sv
// Keypad, product-table, coin-acceptor and dispenser signals of the controller.
interface controle_vendas_param_if
  import controle_vendas_param_pkg::*;
#(
  parameter int unsigned CODE_W  = DefCodeW,
  parameter int unsigned PRICE_W = DefPriceW
);

  logic                codigo_digitado;
  logic [CODE_W-1:0]   codigo;
  logic                consulta_req;
  logic [CODE_W-1:0]   consulta_cod;
  logic                consulta_ack;
  logic                existe_produto;
  logic [PRICE_W-1:0]  preco;
  logic                moeda_valida;
  logic [PRICE_W-1:0]  moeda_valor;
  logic                cancelar;
  logic                moeda_rejeitada;
  logic                dispensa_req;
  logic                dispensa_ack;
  logic                troco_valido;
  logic [PRICE_W-1:0]  troco;
  logic [PRICE_W-1:0]  credito;
  logic [StateW-1:0]   estados;

  // Controller side.
  modport master (
    input  codigo_digitado, codigo, consulta_ack, existe_produto, preco,
           moeda_valida, moeda_valor, cancelar, dispensa_ack,
    output consulta_req, consulta_cod, moeda_rejeitada, dispensa_req,
           troco_valido, troco, credito, estados
  );

  // Environment side: keypad, product table, coin acceptor, dispenser.
  modport slave (
    output codigo_digitado, codigo, consulta_ack, existe_produto, preco,
           moeda_valida, moeda_valor, cancelar, dispensa_ack,
    input  consulta_req, consulta_cod, moeda_rejeitada, dispensa_req,
           troco_valido, troco, credito, estados
  );

endinterface

// File: rtl/controle_vendas_param_contador_timeout.sv
// Idle-cycle counter with clear, enable and a registered terminal-count flag.
module controle_vendas_param_contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 1000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CICLOS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam logic [CNT_W-1:0] Final = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Final)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == Final);

endmodule

// File: rtl/controle_vendas_param.sv
// Vending-machine main controller: lookup, coin credit, dispense and change/refund.
module controle_vendas_param
  import controle_vendas_param_pkg::*;
#(
  parameter int unsigned CODE_W         = DefCodeW,
  parameter int unsigned PRICE_W        = DefPriceW,
  parameter int unsigned TIMEOUT_CICLOS = 1000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CICLOS + 1)
) (
  input logic                     clk,
  input logic                     rst_n,
  controle_vendas_param_if.master bus
);

  estado_e            estado_q, estado_d;
  logic [PRICE_W-1:0] credito_q, credito_d;
  logic [PRICE_W-1:0] preco_q, preco_d;
  logic [PRICE_W-1:0] troco_q, troco_d;
  logic [CODE_W-1:0]  cod_q, cod_d;
  logic               rej_q, rej_d;

  logic               em_pagamento;
  logic               pago;
  logic [PRICE_W:0]   soma_ext;
  logic [PRICE_W-1:0] credito_soma;
  logic               timer_fim;

  assign em_pagamento = (estado_q == Pagamento);
  // Sufficiency is judged on the registered credit, so a coin counts one cycle later.
  assign pago         = (credito_q >= preco_q);
  assign soma_ext     = {1'b0, credito_q} + {1'b0, bus.moeda_valor};
  assign credito_soma = soma_ext[PRICE_W] ? '1 : soma_ext[PRICE_W-1:0];

  // Counts idle cycles in PAGAMENTO; any coin or leaving the state restarts it.
  controle_vendas_param_contador_timeout #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!em_pagamento || bus.moeda_valida),
    .en    (em_pagamento),
    .fim   (timer_fim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= Espera;
      credito_q <= '0;
      preco_q   <= '0;
      troco_q   <= '0;
      cod_q     <= '0;
      rej_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      preco_q   <= preco_d;
      troco_q   <= troco_d;
      cod_q     <= cod_d;
      rej_q     <= rej_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      Espera: begin
        if (bus.codigo_digitado) estado_d = Consulta;
      end
      Consulta: begin
        if (bus.consulta_ack) estado_d = bus.existe_produto ? Pagamento : Espera;
      end
      Pagamento: begin
        if (pago) begin
          estado_d = Dispensa;
        end else if (bus.cancelar || timer_fim) begin
          estado_d = Troco;
        end
      end
      Dispensa: begin
        if (bus.dispensa_ack) estado_d = Troco;
      end
      Troco:   estado_d = Espera;
      default: estado_d = Espera;
    endcase
  end

  always_comb begin
    credito_d = credito_q;
    preco_d   = preco_q;
    troco_d   = troco_q;
    cod_d     = cod_q;
    rej_d     = bus.moeda_valida && !em_pagamento;
    case (estado_q)
      Espera: begin
        if (bus.codigo_digitado) cod_d = bus.codigo;
      end
      Consulta: begin
        if (bus.consulta_ack && bus.existe_produto) preco_d = bus.preco;
      end
      Pagamento: begin
        if (bus.moeda_valida) credito_d = credito_soma;
        // Refund includes a coin landing in the same cycle as cancel/timeout.
        if (!pago && (bus.cancelar || timer_fim)) troco_d = credito_d;
      end
      Dispensa: begin
        if (bus.dispensa_ack) troco_d = pago ? (credito_q - preco_q) : '0;
      end
      Troco:   credito_d = '0;
      default: credito_d = '0;
    endcase
  end

  always_comb begin
    bus.consulta_req    = (estado_q == Consulta);
    bus.dispensa_req    = (estado_q == Dispensa);
    bus.troco_valido    = (estado_q == Troco);
    bus.consulta_cod    = cod_q;
    bus.moeda_rejeitada = rej_q;
    bus.troco           = troco_q;
    bus.credito         = credito_q;
    bus.estados         = estado_q;
  end

endmodule

// File: tb/tb_controle_vendas_param.sv
// Scoreboard bench: transaction model predicts change and coin rejections, a monitor checks them.
module tb_controle_vendas_param;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned PRICE_W = 8;
  localparam int unsigned TMO     = 8;
  localparam int          MAXC    = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controle_vendas_param_if #(.CODE_W(CODE_W), .PRICE_W(PRICE_W)) bus ();

  controle_vendas_param #(
    .CODE_W         (CODE_W),
    .PRICE_W        (PRICE_W),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_troco[$];
  int exp_rej[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int a);
    return (a > MAXC) ? MAXC : a;
  endfunction

  function automatic bit sinal(input int w);
    case (w)
      0:       return bus.consulta_req;
      1:       return bus.dispensa_req;
      2:       return bus.troco_valido;
      default: return bus.estados == 3'd0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string name, input int w, input int budget, output int lat);
    lat = 0;
    while (!sinal(w) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check(name, int'(sinal(w)), 1);
  endtask

  task automatic coin(input int v);
    bus.moeda_valida = 1'b1;
    bus.moeda_valor  = PRICE_W'(v);
    tick(1);
    bus.moeda_valida = 1'b0;
    bus.moeda_valor  = PRICE_W'($urandom);
  endtask

  // Monitor: every change pulse and every coin rejection must have been predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.troco_valido) begin
        if (exp_troco.size() == 0) check("troco_inesperado", int'(bus.troco_valido), 0);
        else check("troco_valor", int'(bus.troco), exp_troco.pop_front());
      end
      if (bus.moeda_rejeitada) begin
        if (exp_rej.size() == 0) check("rejeicao_inesperada", int'(bus.moeda_rejeitada), 0);
        else check("rejeicao_credito", int'(bus.credito), exp_rej.pop_front());
      end
    end
  end

  // mode: 0 pay, 1 cancel (with optional coin 'extra'), 2 let it time out. gap<0 = random.
  task automatic run_txn(input int code, input bit existe, input int price, input int coins[8],
                         input int ncoins, input int mode, input int extra, input bit probe,
                         input int gap);
    int c, lat, g, t;
    c = 0;
    bus.codigo_digitado = 1'b1;
    bus.codigo          = CODE_W'(code);
    tick(1);
    bus.codigo_digitado = 1'b0;
    bus.codigo          = CODE_W'($urandom);
    wait_for("consulta_req", 0, 3, lat);
    check("consulta_cod", int'(bus.consulta_cod), code);
    check("estado_consulta", int'(bus.estados), 1);
    tick($urandom_range(0, 2));
    bus.consulta_ack   = 1'b1;
    bus.existe_produto = existe;
    bus.preco          = PRICE_W'(price);
    tick(1);
    bus.consulta_ack   = 1'b0;
    bus.existe_produto = 1'($urandom);
    bus.preco          = PRICE_W'($urandom);
    if (!existe) begin
      check("estado_inexistente", int'(bus.estados), 0);
      exp_rej.push_back(0);
      coin($urandom_range(1, 255));
      check("credito_rejeitada", int'(bus.credito), 0);
      check("sem_dispensa", int'(bus.dispensa_req), 0);
      return;
    end
    check("estado_pagamento", int'(bus.estados), 2);
    for (int k = 0; k < ncoins && c < price; k++) begin
      g = (gap >= 0) ? gap : ((mode == 2) ? $urandom_range(0, 5) : $urandom_range(0, 2));
      tick(g);
      coin(coins[k]);
      c = sat(c + coins[k]);
      check("credito", int'(bus.credito), c);
    end
    if (c >= price) begin
      wait_for("dispensa_req", 1, 4, lat);
      check("estado_dispensa", int'(bus.estados), 3);
      if (probe) begin
        exp_rej.push_back(c);
        coin($urandom_range(1, 255));
        check("credito_em_dispensa", int'(bus.credito), c);
      end
      tick($urandom_range(0, 2));
      exp_troco.push_back(c - price);
      bus.dispensa_ack = 1'b1;
      tick(1);
      bus.dispensa_ack = 1'b0;
      check("estado_troco", int'(bus.estados), 4);
    end else if (mode == 1) begin
      tick($urandom_range(0, 2));
      t = sat(c + extra);
      exp_troco.push_back(t);
      bus.cancelar = 1'b1;
      if (extra > 0) begin
        bus.moeda_valida = 1'b1;
        bus.moeda_valor  = PRICE_W'(extra);
      end
      tick(1);
      bus.cancelar     = 1'b0;
      bus.moeda_valida = 1'b0;
      check("credito_cancelado", int'(bus.credito), t);
      check("estado_troco_cancel", int'(bus.estados), 4);
    end else begin
      exp_troco.push_back(c);
      wait_for("troco_timeout", 2, 12, lat);
      check("latencia_timeout", lat, int'(TMO));
    end
    tick(1);
    check("estado_final", int'(bus.estados), 0);
    check("credito_final", int'(bus.credito), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cs[8];
    int lat, mode, price, n;
    bus.codigo_digitado = 1'b0;
    bus.codigo          = '0;
    bus.consulta_ack    = 1'b0;
    bus.existe_produto  = 1'b0;
    bus.preco           = '0;
    bus.moeda_valida    = 1'b0;
    bus.moeda_valor     = '0;
    bus.cancelar        = 1'b0;
    bus.dispensa_ack    = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_estados", int'(bus.estados), 0);
    check("rst_credito", int'(bus.credito), 0);
    check("rst_troco", int'(bus.troco), 0);
    check("rst_pulsos", int'({bus.consulta_req, bus.dispensa_req, bus.troco_valido,
                              bus.moeda_rejeitada}), 0);
    check("rst_consulta_cod", int'(bus.consulta_cod), 0);
    rst_n = 1'b1;
    tick(2);

    cs = '{20, 30, 0, 0, 0, 0, 0, 0};
    run_txn(3, 1'b1, 50, cs, 2, 0, 0, 1'b0, -1);
    cs = '{20, 20, 20, 0, 0, 0, 0, 0};
    run_txn(5, 1'b1, 50, cs, 3, 0, 0, 1'b1, -1);
    run_txn(7, 1'b0, 50, cs, 0, 0, 0, 1'b0, -1);
    cs = '{30, 0, 0, 0, 0, 0, 0, 0};
    run_txn(1, 1'b1, 100, cs, 1, 1, 10, 1'b0, -1);
    cs = '{10, 0, 0, 0, 0, 0, 0, 0};
    run_txn(2, 1'b1, 50, cs, 1, 2, 0, 1'b0, -1);
    cs = '{10, 10, 10, 0, 0, 0, 0, 0};
    run_txn(4, 1'b1, 200, cs, 3, 2, 0, 1'b0, 6);
    cs = '{200, 100, 0, 0, 0, 0, 0, 0};
    run_txn(9, 1'b1, 255, cs, 2, 0, 0, 1'b0, -1);
    run_txn(6, 1'b1, 0, cs, 0, 0, 0, 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        price = $urandom_range(0, 255);
        foreach (cs[j]) cs[j] = $urandom_range(40, 255);
        n = 8;
      end else begin
        price = $urandom_range(1, 255);
        foreach (cs[j]) cs[j] = $urandom_range(1, 60);
        n = $urandom_range(0, 3);
      end
      run_txn($urandom_range(0, 15), ($urandom_range(0, 4) != 0), price, cs, n, mode,
              $urandom_range(0, 1) ? $urandom_range(1, 255) : 0, 1'($urandom), -1);
    end

    // Reset while the dispenser is busy: everything clears at once, no change pulse.
    cs = '{50, 0, 0, 0, 0, 0, 0, 0};
    bus.codigo_digitado = 1'b1;
    bus.codigo          = CODE_W'(8);
    tick(1);
    bus.codigo_digitado = 1'b0;
    bus.consulta_ack    = 1'b1;
    bus.existe_produto  = 1'b1;
    bus.preco           = PRICE_W'(10);
    tick(1);
    bus.consulta_ack    = 1'b0;
    coin(50);
    wait_for("dispensa_antes_reset", 1, 4, lat);
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_estados", int'(bus.estados), 0);
    check("reset_async_dispensa", int'(bus.dispensa_req), 0);
    check("reset_async_credito", int'(bus.credito), 0);
    check("reset_async_troco", int'(bus.troco), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("sem_troco_apos_reset", int'(bus.troco_valido), 0);

    check("fila_troco_vazia", exp_troco.size(), 0);
    check("fila_rejeicao_vazia", exp_rej.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controle_vendas_param.md
Name: controle_vendas_param

Overview:
Parametrised main controller for the vending machine: the successor to the three-state wait/product/compare controller. It adds a product-lookup handshake, coin-credit accumulation, cancel/timeout refund, dispense handshake and change output. It sits between the keypad/code decoder, the product table, the coin acceptor and the dispenser/change mechanism.

Parameters:
CODE_W, 4, width of product code
PRICE_W, 8, width of price, coin value, credit and change (currency units)
TIMEOUT_CICLOS, 1000, idle cycles in PAGAMENTO before automatic refund (>=2)
CNT_W, $clog2(TIMEOUT_CICLOS+1), width of timeout counter (derived)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
codigo_digitado  in  1  one-cycle pulse: code entry complete
codigo  in  CODE_W  product code, valid with codigo_digitado
consulta_req  out  1  lookup request to product table
consulta_cod  out  CODE_W  registered code under lookup
consulta_ack  in  1  lookup response valid
existe_produto  in  1  product exists and is in stock, valid with consulta_ack
preco  in  PRICE_W  product price, valid with consulta_ack
moeda_valida  in  1  one-cycle pulse: coin inserted
moeda_valor  in  PRICE_W  coin value, valid with moeda_valida
cancelar  in  1  user cancel pulse
moeda_rejeitada  out  1  one-cycle pulse: coin not accepted, return it
dispensa_req  out  1  dispense request
dispensa_ack  in  1  dispenser done
troco_valido  out  1  one-cycle pulse: troco valid
troco  out  PRICE_W  change/refund amount
credito  out  PRICE_W  current credit (display)
estados  out  3  current state encoding

Behaviour:
- Async reset (rst_n low): state ESPERA, credito=0, preco_reg=0, consulta_cod=0, timeout counter=0; all request/pulse outputs 0; troco=0; estados=3'b000.
- Registered state; all outputs decoded from registered state/registers (Moore); no combinational input-to-output path.
- States/encoding: ESPERA 000, CONSULTA 001, PAGAMENTO 010, DISPENSA 011, TROCO 100; 101-111 illegal -> ESPERA next cycle, credito cleared.
- ESPERA: codigo_digitado -> latch codigo into consulta_cod, go CONSULTA.
- CONSULTA: consulta_req=1 until consulta_ack. On ack: existe_produto=1 -> latch preco, clear timer, go PAGAMENTO; else -> ESPERA. codigo_digitado ignored.
- PAGAMENTO: moeda_valida adds moeda_valor to credito, saturating at 2^PRICE_W-1, and clears timer; otherwise timer increments.
  - Credit check uses the registered credito: credito >= preco_reg -> DISPENSA (preco 0 -> DISPENSA one cycle after entry).
  - cancelar or timer==TIMEOUT_CICLOS-1 -> TROCO with troco=credito (full refund).
  - Priority: credit sufficient > cancel > timeout. A coin arriving in the same cycle as cancel/timeout is added first, and the refund includes it.
- DISPENSA: dispensa_req=1 held until dispensa_ack. On ack: troco<=credito-preco_reg (never negative), go TROCO. cancelar ignored.
- TROCO: troco_valido=1 for exactly one cycle (even when troco=0); credito<=0; go ESPERA. troco holds its value until the next TROCO.
- Coin in any state other than PAGAMENTO: moeda_rejeitada pulses the next cycle; credit unchanged.
- credito output = credit register; latency coin->credito 1 cycle.
- estados = state encoding.
- rst_n asserted mid-transaction: credit is lost, no troco pulse (a hardware refund is out of scope).

Decomposition:
- Shared package vendas_pkg: state localparams (ESPERA..TROCO), state width 3, default PRICE_W/CODE_W.
- One natural sub-module: contador_timeout (clear/enable/terminal-count, parametrised by TIMEOUT_CICLOS).
- The rest is a single FSM plus datapath.

Test Plan:
- Exact payment: code 3, ack existe=1 preco=50, coins 20+30 -> DISPENSA; after ack, troco_valido with troco=0; back in ESPERA, credito=0.
- Overpay: preco=50, coins 20+20+20 -> after dispensa_ack, troco=10 pulse for 1 cycle; estados sequence 001,010,011,100,000.
- Unknown product: ack existe=0 -> ESPERA in 1 cycle, no dispensa_req; a coin then gives moeda_rejeitada=1.
- Cancel with simultaneous coin: credito=30, cancelar+coin 10 same cycle -> troco=40, no dispense.
- Timeout: TIMEOUT_CICLOS=8, preco=50, coin 10, then idle 8 cycles -> TROCO, troco=10; a coin at cycle 7 restarts the count.
- Saturation/reset: PRICE_W=8, coins 200+100 -> credito=255. rst_n low mid-DISPENSA -> all outputs 0 immediately (async), estados=000.
